// File: rtl/norz_seq_pkg.sv
// Shared types and constants for the NORZ phase sequencer: state encoding,
// default parameter values and datapath widths.
package norz_seq_pkg;

  localparam int XPT_W    = 4;
  localparam int ITABLE_W = 8;
  localparam int RET_W    = 16;

  localparam logic [ITABLE_W-1:0] IRQ_OPCODE_DEF = 8'hFF;
  localparam logic [XPT_W-1:0]    XPT_LIMIT_DEF  = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/norz_xpt_counter.sv
// Execution-phase counter with clear/increment/hold and a separately
// registered complement so the decoder sees glitch-free true/inverse pairs.
module norz_xpt_counter
  import norz_seq_pkg::*;
#(
  parameter logic [XPT_W-1:0] LIMIT = XPT_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             notReset,
  input  logic             clr,
  input  logic             inc,
  output logic [XPT_W-1:0] xpt,
  output logic [XPT_W-1:0] not_xpt,
  output logic             at_limit
);

  logic [XPT_W-1:0] xpt_reg;
  logic [XPT_W-1:0] xpt_next;

  always_comb begin
    xpt_next = xpt_reg;
    if (clr) begin
      xpt_next = '0;
    end else if (inc) begin
      xpt_next = xpt_reg + XPT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!notReset) begin
      xpt_reg <= '0;
    end else begin
      xpt_reg <= xpt_next;
    end
  end

  // Each complement bit is its own flop, loaded from the inverted next value.
  genvar gi;
  generate
    for (gi = 0; gi < XPT_W; gi++) begin : g_not_xpt
      logic not_bit_reg;
      always_ff @(posedge clk) begin
        if (!notReset) begin
          not_bit_reg <= 1'b1;
        end else begin
          not_bit_reg <= ~xpt_next[gi];
        end
      end
      assign not_xpt[gi] = not_bit_reg;
    end
  endgenerate

  assign xpt      = xpt_reg;
  assign at_limit = (xpt_reg == LIMIT);

endmodule

// File: rtl/norz_phase_sequencer.sv
// Sequencer for the NORZ decoder tree: fetch/execute/halt control, instruction
// latch, interrupt injection, phase-overrun detection and retire counting.
module norz_phase_sequencer
  import norz_seq_pkg::*;
#(
  parameter logic [ITABLE_W-1:0] IRQ_OPCODE = IRQ_OPCODE_DEF,
  parameter logic [XPT_W-1:0]    XPT_LIMIT  = XPT_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                notReset,
  input  logic                mem_ready,
  input  logic [ITABLE_W-1:0] opcode_in,
  input  logic                irq_req,
  input  logic                irq_en,
  input  logic                PR_Reset_XPT,
  input  logic                P2_Set_CM1,
  input  logic                P2_Reset_ITABLE,
  input  logic                Pa_Ophd,
  input  logic                PC_R0,
  input  logic                PC_R1,
  input  logic                PC_R2,
  input  logic                PC_W0,
  input  logic                PC_W1,
  input  logic                PC_W2,
  output logic                enable,
  output logic [XPT_W-1:0]    XPT,
  output logic [XPT_W-1:0]    notXPT,
  output logic [ITABLE_W-1:0] ITABLE,
  output logic [ITABLE_W-1:0] notITABLE,
  output logic                CM1,
  output logic                irq_ack,
  output logic                fault,
  output logic [RET_W-1:0]    retired
);

  seq_state_e          state_reg, state_next;
  logic [ITABLE_W-1:0] itable_reg, itable_next;
  logic [ITABLE_W-1:0] not_itable_reg;
  logic                irq_ack_reg, irq_ack_next;
  logic                fault_reg, fault_next;
  logic [RET_W-1:0]    retired_reg, retired_next;
  logic                xpt_clr, xpt_inc, xpt_at_limit;
  logic                bus_cycle, stall;

  norz_xpt_counter #(.LIMIT(XPT_LIMIT)) u_xpt (
    .clk      (clk),
    .notReset (notReset),
    .clr      (xpt_clr),
    .inc      (xpt_inc),
    .xpt      (XPT),
    .not_xpt  (notXPT),
    .at_limit (xpt_at_limit)
  );

  assign bus_cycle = PC_R0 | PC_R1 | PC_R2 | PC_W0 | PC_W1 | PC_W2;
  assign stall     = bus_cycle & ~mem_ready;

  always_comb begin
    state_next   = state_reg;
    itable_next  = itable_reg;
    irq_ack_next = 1'b0;
    fault_next   = fault_reg;
    retired_next = retired_reg;
    xpt_clr      = 1'b0;
    xpt_inc      = 1'b0;
    case (state_reg)
      FETCH: begin
        if (mem_ready) begin
          xpt_clr    = 1'b1;
          state_next = EXEC;
          if (irq_req && irq_en) begin
            itable_next  = IRQ_OPCODE;
            irq_ack_next = 1'b1;
          end else begin
            itable_next = opcode_in;
          end
        end
      end
      EXEC: begin
        // A stalled bus cycle freezes everything, housekeeping strobes included.
        if (!stall) begin
          if (Pa_Ophd) begin
            retired_next = retired_reg + RET_W'(1);
          end
          if (PR_Reset_XPT) begin
            xpt_clr = 1'b1;
            if (P2_Set_CM1) begin
              state_next = FETCH;
            end
            if (P2_Reset_ITABLE) begin
              itable_next = '0;
            end
          end else if (xpt_at_limit) begin
            fault_next = 1'b1;
            state_next = HALT;
          end else begin
            xpt_inc = 1'b1;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!notReset) begin
      state_reg      <= FETCH;
      itable_reg     <= '0;
      not_itable_reg <= '1;
      irq_ack_reg    <= 1'b0;
      fault_reg      <= 1'b0;
      retired_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      itable_reg     <= itable_next;
      not_itable_reg <= ~itable_next;
      irq_ack_reg    <= irq_ack_next;
      fault_reg      <= fault_next;
      retired_reg    <= retired_next;
    end
  end

  assign enable    = (state_reg == EXEC);
  assign CM1       = (state_reg == FETCH);
  assign ITABLE    = itable_reg;
  assign notITABLE = not_itable_reg;
  assign irq_ack   = irq_ack_reg;
  assign fault     = fault_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_norz_phase_sequencer.sv
// Directed bench for norz_phase_sequencer: each step queues the expected
// post-edge outputs, then pops and compares them after the clock edge.
module tb_norz_phase_sequencer;

  logic        clk = 1'b0;
  logic        notReset;
  logic        mem_ready;
  logic [7:0]  opcode_in;
  logic        irq_req, irq_en;
  logic        PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd;
  logic        PC_R0, PC_R1, PC_R2, PC_W0, PC_W1, PC_W2;
  logic        enable;
  logic [3:0]  XPT, notXPT;
  logic [7:0]  ITABLE, notITABLE;
  logic        CM1, irq_ack, fault;
  logic [15:0] retired;

  always #5 clk = ~clk;

  norz_phase_sequencer dut (
    .clk             (clk),
    .notReset        (notReset),
    .mem_ready       (mem_ready),
    .opcode_in       (opcode_in),
    .irq_req         (irq_req),
    .irq_en          (irq_en),
    .PR_Reset_XPT    (PR_Reset_XPT),
    .P2_Set_CM1      (P2_Set_CM1),
    .P2_Reset_ITABLE (P2_Reset_ITABLE),
    .Pa_Ophd         (Pa_Ophd),
    .PC_R0           (PC_R0),
    .PC_R1           (PC_R1),
    .PC_R2           (PC_R2),
    .PC_W0           (PC_W0),
    .PC_W1           (PC_W1),
    .PC_W2           (PC_W2),
    .enable          (enable),
    .XPT             (XPT),
    .notXPT          (notXPT),
    .ITABLE          (ITABLE),
    .notITABLE       (notITABLE),
    .CM1             (CM1),
    .irq_ack         (irq_ack),
    .fault           (fault),
    .retired         (retired)
  );

  typedef struct {
    string       tag;
    logic [3:0]  xpt;
    logic [7:0]  itable;
    logic        en;
    logic        cm1;
    logic        ack;
    logic        flt;
    logic [15:0] ret;
  } exp_t;

  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  function automatic exp_t mk(input string tag, input logic [3:0] x, input logic [7:0] it,
                              input logic en, input logic cm1, input logic ack,
                              input logic flt, input logic [15:0] r);
    exp_t e;
    e.tag = tag; e.xpt = x; e.itable = it; e.en = en; e.cm1 = cm1;
    e.ack = ack; e.flt = flt; e.ret = r;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks_total++;
    assert (got === want) checks_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [3:0] nx;
    logic [7:0] nit;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
      return;
    end
    e   = sb.pop_front();
    nx  = ~e.xpt;
    nit = ~e.itable;
    $display("[%0t] %s XPT=%h ITABLE=%h en=%b CM1=%b ack=%b fault=%b retired=%h",
             $time, e.tag, XPT, ITABLE, enable, CM1, irq_ack, fault, retired);
    chk({e.tag, ".XPT"},       {12'h0, XPT},       {12'h0, e.xpt});
    chk({e.tag, ".notXPT"},    {12'h0, notXPT},    {12'h0, nx});
    chk({e.tag, ".ITABLE"},    {8'h0, ITABLE},     {8'h0, e.itable});
    chk({e.tag, ".notITABLE"}, {8'h0, notITABLE},  {8'h0, nit});
    chk({e.tag, ".enable"},    {15'h0, enable},    {15'h0, e.en});
    chk({e.tag, ".CM1"},       {15'h0, CM1},       {15'h0, e.cm1});
    chk({e.tag, ".irq_ack"},   {15'h0, irq_ack},   {15'h0, e.ack});
    chk({e.tag, ".fault"},     {15'h0, fault},     {15'h0, e.flt});
    chk({e.tag, ".retired"},   retired,            e.ret);
  endtask

  task automatic step(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic strobes(input logic pr, input logic set, input logic rst, input logic pa);
    PR_Reset_XPT = pr; P2_Set_CM1 = set; P2_Reset_ITABLE = rst; Pa_Ophd = pa;
  endtask

  initial begin
    notReset = 1'b0; mem_ready = 1'b0; opcode_in = 8'h00; irq_req = 1'b0; irq_en = 1'b0;
    strobes(0, 0, 0, 0);
    {PC_R0, PC_R1, PC_R2, PC_W0, PC_W1, PC_W2} = 6'b0;

    step(mk("reset", 4'h0, 8'h00, 0, 1, 0, 0, 16'd0));
    notReset = 1'b1;
    for (int i = 0; i < 3; i++) step(mk("fetch_wait", 4'h0, 8'h00, 0, 1, 0, 0, 16'd0));
    mem_ready = 1'b1; opcode_in = 8'h3A;
    step(mk("fetch_3a", 4'h0, 8'h3A, 1, 0, 0, 0, 16'd0));
    mem_ready = 1'b0; opcode_in = 8'h00;
    step(mk("exec_x1", 4'h1, 8'h3A, 1, 0, 0, 0, 16'd0));
    step(mk("exec_x2", 4'h2, 8'h3A, 1, 0, 0, 0, 16'd0));
    strobes(1, 1, 1, 1);
    step(mk("finish", 4'h0, 8'h00, 0, 1, 0, 0, 16'd1));
    strobes(0, 0, 0, 0);

    // Bus stall with a pending PR_Reset_XPT and Pa_Ophd held off until ready.
    mem_ready = 1'b1; opcode_in = 8'h55;
    step(mk("fetch_55", 4'h0, 8'h55, 1, 0, 0, 0, 16'd1));
    mem_ready = 1'b0;
    step(mk("exec_x1b", 4'h1, 8'h55, 1, 0, 0, 0, 16'd1));
    PC_R1 = 1'b1; strobes(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(mk("stall", 4'h1, 8'h55, 1, 0, 0, 0, 16'd1));
    mem_ready = 1'b1;
    step(mk("stall_release", 4'h0, 8'h55, 1, 0, 0, 0, 16'd2));
    PC_R1 = 1'b0; mem_ready = 1'b0; strobes(1, 1, 0, 0);
    step(mk("boundary", 4'h0, 8'h55, 0, 1, 0, 0, 16'd2));
    strobes(0, 0, 0, 0);

    // Interrupt taken, then an enabled request outside fetch is ignored.
    irq_req = 1'b1; irq_en = 1'b1; opcode_in = 8'h12; mem_ready = 1'b1;
    step(mk("irq_take", 4'h0, 8'hFF, 1, 0, 1, 0, 16'd2));
    mem_ready = 1'b0;
    step(mk("irq_ack_end", 4'h1, 8'hFF, 1, 0, 0, 0, 16'd2));
    strobes(1, 1, 0, 0);
    step(mk("irq_done", 4'h0, 8'hFF, 0, 1, 0, 0, 16'd2));
    strobes(0, 0, 0, 0);
    irq_en = 1'b0; mem_ready = 1'b1;
    step(mk("irq_masked", 4'h0, 8'h12, 1, 0, 0, 0, 16'd2));
    irq_req = 1'b0; mem_ready = 1'b0;

    // Overrun: phases 1..15, then the cycle at 15 faults and halts.
    for (int i = 1; i < 16; i++) step(mk("run", 4'(i), 8'h12, 1, 0, 0, 0, 16'd2));
    step(mk("overrun", 4'hF, 8'h12, 0, 0, 0, 1, 16'd2));
    mem_ready = 1'b1; strobes(1, 1, 1, 1);
    step(mk("halt_hold", 4'hF, 8'h12, 0, 0, 0, 1, 16'd2));
    notReset = 1'b0;
    step(mk("halt_reset", 4'h0, 8'h00, 0, 1, 0, 0, 16'd0));
    notReset = 1'b1; strobes(0, 0, 0, 0); opcode_in = 8'h77;

    // Retire counter wrap.
    step(mk("fetch_77", 4'h0, 8'h77, 1, 0, 0, 0, 16'd0));
    mem_ready = 1'b0; strobes(1, 0, 0, 1);
    repeat (65534) @(posedge clk);
    #1;
    step(mk("retire_ffff", 4'h0, 8'h77, 1, 0, 0, 0, 16'hFFFF));
    step(mk("retire_wrap", 4'h0, 8'h77, 1, 0, 0, 0, 16'h0000));
    strobes(0, 0, 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
